// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared datapath.
// Latency: 2-5 cycles per instruction (lw 5; sw/R/addi 4; beq/j/jal 3; unknown 2; halt 2 then parks).
// Backpressure: with MEM_WAIT_EN defined, FETCH/MEM_READ/MEM_WRITE stall while mem_ready=0; otherwise none.
//
// Ports: clock/reset (sync, active-high); opcode = IR[31:26]; zero_flag from ALU; mem_ready memory handshake.
//   Outputs: datapath enables/selects (pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
//   mem_to_reg, write_link, alu_src_a, alu_src_b, ALUOp, pc_source), illegal_op pulse, halted, debug state,
//   instr_count (retired instructions, COUNT_W bits, wraps).
// Optional feature macro: MEM_WAIT_EN (memory wait states gated by mem_ready).
module controle_multiciclo #(
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero_flag,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               write_link,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         ALUOp,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               halted,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_t             cur;
  logic               jal_q;   // JUMP no longer samples opcode, so remember jal from DECODE
  logic [COUNT_W-1:0] cnt_q;
  logic               mem_ok;
  logic               op_known;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  always_comb begin
    case (opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_HALT: op_known = 1'b1;
      default:                                                   op_known = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur   <= S_FETCH;
      jal_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (cur)
        S_FETCH:     if (mem_ok) cur <= S_DECODE;
        S_DECODE: begin
          jal_q <= (opcode == OP_JAL);
          case (opcode)
            OP_R:          cur <= S_R_EXEC;
            OP_LW, OP_SW:  cur <= S_MEM_ADDR;
            OP_BEQ:        cur <= S_BRANCH;
            OP_J, OP_JAL:  cur <= S_JUMP;
            OP_ADDI:       cur <= S_I_EXEC;
            OP_HALT: begin
              cur   <= S_HALT;
              cnt_q <= cnt_q + CNT_ONE;
            end
            default:       cur <= S_FETCH;  // illegal: not retired
          endcase
        end
        S_MEM_ADDR:  cur <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ok) cur <= S_MEM_WB;
        S_MEM_WRITE: begin
          if (mem_ok) begin
            cur   <= S_FETCH;
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
          cur   <= S_FETCH;
          cnt_q <= cnt_q + CNT_ONE;
        end
        S_R_EXEC:    cur <= S_R_WB;
        S_I_EXEC:    cur <= S_I_WB;
        S_HALT:      cur <= S_HALT;
        default:     cur <= S_FETCH;  // unused codes 13-15
      endcase
    end
  end

  // Moore decode of state; reset blanks every output so nothing writes mid-reset.
  always_comb begin
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    write_link = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ALUOp      = 4'b0000;
    pc_source  = 2'b00;
    illegal_op = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = mem_ok;
          pc_write  = mem_ok;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;  // branch target into ALUOut
          illegal_op = !op_known;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          ALUOp     = 4'b0010;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          ALUOp     = 4'b0001;
          pc_source = 2'b01;
          pc_write  = zero_flag;
        end
        S_JUMP: begin
          pc_source  = 2'b10;
          pc_write   = 1'b1;
          reg_write  = jal_q;  // $31 <- PC+4, already in PC since FETCH
          write_link = jal_q;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_I_WB:  reg_write = 1'b1;
        S_HALT:  halted    = 1'b1;
        default: ;
      endcase
    end
  end

  assign state       = reset ? 4'd0 : cur;
  assign instr_count = reset ? '0 : cnt_q;

endmodule
